draw_arbiter: RTL and testbench
===============================

// Module: draw_arbiter
// PURPOSE
//  Arbitrates VGA drawing between the self (player) datapath and the enemy datapath.
//  Each datapath requests a draw window; the arbiter grants one at a time and drives datapath_select
//  (0=self, 1=enemy) into the datapath mux, which steers x/y/color to the VGA adapter.
//  Forwards the granted datapath's plot strobe as the single VGA plot enable.
// PARAMETERS
//  GAP_CYCLES  1      idle cycles inserted between releasing one grant and issuing the next (>=1)
//  WD_CYCLES   20000  max grant length before forced release (only with DRAW_ARB_WATCHDOG_EN)
// PORTS
//  clock          in   1  system clock, all state on rising edge
//  resetn         in   1  asynchronous, active-low reset
//  req_self       in   1  self datapath requests a draw window (level)
//  req_enemy      in   1  enemy datapath requests a draw window (level)
//  done_self      in   1  self datapath finished drawing (1-cycle pulse)
//  done_enemy     in   1  enemy datapath finished drawing (1-cycle pulse)
//  plot_self      in   1  self datapath pixel write strobe
//  plot_enemy     in   1  enemy datapath pixel write strobe
//  grant_self     out  1  self owns the VGA port
//  grant_enemy    out  1  enemy owns the VGA port
//  datapath_select out 1  mux select: 0=self, 1=enemy
//  plot           out  1  VGA write enable
//  busy           out  1  high in any state other than IDLE
//  wd_timeout     out  1  1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grants=0, datapath_select=0, busy=0, wd_timeout=0,
//   last_served=ENEMY (so self wins first contention). Reset mid-grant drops the grant at once.
//  States: IDLE, GNT_SELF, GNT_ENEMY, GAP.
//  IDLE: sample reqs; only one high -> grant it; both high -> grant the one != last_served;
//   none -> stay. Grant visible the cycle after req is sampled (1-cycle latency).
//  GNT_x: grant_x=1, datapath_select = x; done_x sampled -> next cycle grant_x=0,
//   last_served=x, enter GAP. req_x dropping without done_x is ignored; grant is held.
//   done from the non-granted datapath is ignored in every state.
//  GAP: counter loads GAP_CYCLES-1 on entry, decrements; at 0 -> IDLE. Reqs ignored in GAP.
//   Total: done sampled at edge N -> grant low after N; next grant earliest after N+GAP_CYCLES+1.
//  datapath_select is registered; it holds its last value through GAP and IDLE (no glitch to mux).
//  plot = (grant_self & plot_self) | (grant_enemy & plot_enemy), combinational; never 1 without a grant.
//  grant_self and grant_enemy are never both 1 (one-hot or zero by construction).
//  busy = (state != IDLE).
// CONFIGURATION
//  DRAW_ARB_WATCHDOG_EN defined: a counter runs while in GNT_x; reaching WD_CYCLES-1 without done
//   forces the same exit as done (grant low next cycle, last_served=x, GAP) and pulses wd_timeout
//   for one cycle. done on the same cycle as expiry counts as a normal done; no wd_timeout.
//  Not defined: no watchdog counter; grant held indefinitely until done; wd_timeout tied 0.
// STRUCTURE
//  draw_arb_pkg: state enum (IDLE, GNT_SELF, GNT_ENEMY, GAP), SEL_SELF=1'b0, SEL_ENEMY=1'b1,
//   counter width derived from max(GAP_CYCLES, WD_CYCLES) via $clog2.
//  Sub-module draw_arb_timer: loadable down-counter with zero flag, shared by GAP and watchdog
//   (never active in the same state). Top holds FSM, last_served, output gating.
// TESTING
//  1. Reset, req_self=1 only -> grant_self=1, select=0 one cycle later; done_self -> grant low next cycle.
//  2. Both reqs high from reset -> self granted first; after done + GAP_CYCLES, enemy granted, select=1.
//  3. Both held high across 4 draws -> strict alternation self,enemy,self,enemy.
//  4. plot_enemy toggling while self granted -> plot follows plot_self only; done_enemy ignored.
//  5. Assert resetn=0 mid GNT_ENEMY -> grants, busy, select drop to 0 without a clock edge.
//  6. WATCHDOG_EN, WD_CYCLES=8, no done -> grant drops after 8 cycles, wd_timeout 1-cycle pulse.

Source files
------------

// File: rtl/draw_arb_pkg.sv
// draw_arb_pkg: shared types and constants for the VGA draw arbiter.
// Holds the arbiter state encoding, the datapath-select values used by the
// mux, and the helper that sizes the shared GAP/watchdog down-counter.
package draw_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GNT_SELF  = 2'd1,
      GNT_ENEMY = 2'd2,
      GAP       = 2'd3
   } arb_state_t;

   // datapath_select encoding as seen by the x/y/color mux
   localparam logic SEL_SELF  = 1'b0;
   localparam logic SEL_ENEMY = 1'b1;

   // Counter must hold values up to max(gap, wd) - 1; never narrower than 1 bit.
   function automatic int cnt_width(input int gap_cycles, input int wd_cycles);
      int m;
      m = (gap_cycles > wd_cycles) ? gap_cycles : wd_cycles;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/draw_arb_timer.sv
// draw_arb_timer: loadable down-counter with a zero flag.
// One instance is shared between the GAP interval and the grant watchdog;
// the two are never active in the same arbiter state, so a single counter
// serves both. Decrementing saturates at zero.
module draw_arb_timer #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // Load has priority over decrement; hold at zero once reached.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter: grants the VGA drawing port to either the self (player)
// datapath or the enemy datapath, one at a time, with round-robin on
// contention and an idle gap between grants. Drives the datapath mux select
// and forwards the owner's plot strobe as the VGA write enable.
// Optional feature: define DRAW_ARB_WATCHDOG_EN to force release of a grant
// held for WD_CYCLES cycles without a done pulse (wd_timeout pulses once).
module draw_arbiter
   import draw_arb_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter int WD_CYCLES  = 20000
) (
   input  logic clock,
   input  logic resetn,
   input  logic req_self,
   input  logic req_enemy,
   input  logic done_self,
   input  logic done_enemy,
   input  logic plot_self,
   input  logic plot_enemy,
   output logic grant_self,
   output logic grant_enemy,
   output logic datapath_select,
   output logic plot,
   output logic busy,
   output logic wd_timeout
);

   localparam int CNT_W = cnt_width(GAP_CYCLES, WD_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
`ifdef DRAW_ARB_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(WD_CYCLES - 1);
`endif

   arb_state_t       state;
   logic             last_served;
   logic             done_gnt;
   logic             wd_expire;
   logic             tmr_load;
   logic             tmr_dec;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_zero;

   // A done pulse only counts when it comes from the datapath that holds the grant.
   always_comb begin
      done_gnt = ((state == GNT_SELF)  && done_self) ||
                 ((state == GNT_ENEMY) && done_enemy);
   end

`ifdef DRAW_ARB_WATCHDOG_EN
   // Watchdog expiry: counter hit zero while granted; a simultaneous done wins.
   always_comb begin
      wd_expire = ((state == GNT_SELF) || (state == GNT_ENEMY)) &&
                  tmr_zero && !done_gnt;
   end
`else
   assign wd_expire = 1'b0;
`endif

   // Timer control: load GAP length on release, count down through GAP;
   // with the watchdog, also load the grant limit on grant and count while granted.
   always_comb begin
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;
      tmr_load_val = GAP_LOAD;
      case (state)
`ifdef DRAW_ARB_WATCHDOG_EN
         IDLE: begin
            if (req_self || req_enemy) begin
               tmr_load     = 1'b1;
               tmr_load_val = WD_LOAD;
            end
         end
`endif
         GNT_SELF, GNT_ENEMY: begin
            if (done_gnt || wd_expire) begin
               tmr_load = 1'b1;
`ifdef DRAW_ARB_WATCHDOG_EN
            end else begin
               tmr_dec  = 1'b1;
`endif
            end
         end
         GAP: begin
            tmr_dec = 1'b1;
         end
         default: begin
         end
      endcase
   end

   draw_arb_timer #(
      .W (CNT_W)
   ) u_timer (
      .clock    (clock),
      .resetn   (resetn),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .load_val (tmr_load_val),
      .zero     (tmr_zero)
   );

   // Arbiter FSM with registered grants, select, busy and watchdog pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         grant_self      <= 1'b0;
         grant_enemy     <= 1'b0;
         datapath_select <= SEL_SELF;
         busy            <= 1'b0;
         wd_timeout      <= 1'b0;
         last_served     <= SEL_ENEMY;
      end else begin
         wd_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (req_self && (!req_enemy || (last_served == SEL_ENEMY))) begin
                  state           <= GNT_SELF;
                  grant_self      <= 1'b1;
                  datapath_select <= SEL_SELF;
                  busy            <= 1'b1;
               end else if (req_enemy) begin
                  state           <= GNT_ENEMY;
                  grant_enemy     <= 1'b1;
                  datapath_select <= SEL_ENEMY;
                  busy            <= 1'b1;
               end
            end
            GNT_SELF: begin
               if (done_self || wd_expire) begin
                  state       <= GAP;
                  grant_self  <= 1'b0;
                  last_served <= SEL_SELF;
                  wd_timeout  <= wd_expire;
               end
            end
            GNT_ENEMY: begin
               if (done_enemy || wd_expire) begin
                  state       <= GAP;
                  grant_enemy <= 1'b0;
                  last_served <= SEL_ENEMY;
                  wd_timeout  <= wd_expire;
               end
            end
            GAP: begin
               if (tmr_zero) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               grant_self  <= 1'b0;
               grant_enemy <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

   // VGA write enable follows only the owner's strobe.
   always_comb begin
      plot = (grant_self & plot_self) | (grant_enemy & plot_enemy);
   end

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed bench for draw_arbiter (GAP_CYCLES=1, WD_CYCLES=8).
// Covers the watchdog path when DRAW_ARB_WATCHDOG_EN is defined, and the
// hold-forever path otherwise.
module tb_draw_arbiter;

   logic clock;
   logic resetn;
   logic req_self, req_enemy;
   logic done_self, done_enemy;
   logic plot_self, plot_enemy;
   logic grant_self, grant_enemy;
   logic datapath_select;
   logic plot;
   logic busy;
   logic wd_timeout;

   int vectors;
   int miscompares;

   draw_arbiter #(
      .GAP_CYCLES (1),
      .WD_CYCLES  (8)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .req_self        (req_self),
      .req_enemy       (req_enemy),
      .done_self       (done_self),
      .done_enemy      (done_enemy),
      .plot_self       (plot_self),
      .plot_enemy      (plot_enemy),
      .grant_self      (grant_self),
      .grant_enemy     (grant_enemy),
      .datapath_select (datapath_select),
      .plot            (plot),
      .busy            (busy),
      .wd_timeout      (wd_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle 1 time unit past it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      req_self   = 1'b0;
      req_enemy  = 1'b0;
      done_self  = 1'b0;
      done_enemy = 1'b0;
      plot_self  = 1'b0;
      plot_enemy = 1'b0;
      resetn     = 1'b0;
      tick();
      resetn     = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      do_reset();

      // reset state
      check("rst_grant_self",  grant_self,      1'b0);
      check("rst_grant_enemy", grant_enemy,     1'b0);
      check("rst_select",      datapath_select, 1'b0);
      check("rst_busy",        busy,            1'b0);
      check("rst_wd_timeout",  wd_timeout,      1'b0);
      check("rst_plot",        plot,            1'b0);

      // 1: single self request, one-cycle latency, release after done
      req_self = 1'b1;
      tick();
      check("t1_grant_self", grant_self,      1'b1);
      check("t1_select",     datapath_select, 1'b0);
      check("t1_busy",       busy,            1'b1);
      plot_self = 1'b1;
      #1;
      check("t1_plot", plot, 1'b1);
      plot_self = 1'b0;
      done_self = 1'b1;
      tick();
      done_self = 1'b0;
      req_self  = 1'b0;
      check("t1_release", grant_self, 1'b0);
      check("t1_gap_busy", busy, 1'b1);
      tick();
      check("t1_idle_busy", busy, 1'b0);

      // 2+3: both requests from reset -> self first, then strict alternation
      do_reset();
      req_self  = 1'b1;
      req_enemy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic exp_en;
         exp_en = k[0];
         tick();
         check($sformatf("alt%0d_grant_self", k),  grant_self,      ~exp_en);
         check($sformatf("alt%0d_grant_enemy", k), grant_enemy,     exp_en);
         check($sformatf("alt%0d_select", k),      datapath_select, exp_en);
         if (exp_en) done_enemy = 1'b1;
         else        done_self  = 1'b1;
         tick();
         done_self  = 1'b0;
         done_enemy = 1'b0;
         check($sformatf("alt%0d_gap_self", k),   grant_self,      1'b0);
         check($sformatf("alt%0d_gap_enemy", k),  grant_enemy,     1'b0);
         check($sformatf("alt%0d_gap_select", k), datapath_select, exp_en);
         tick();
         check($sformatf("alt%0d_idle_self", k),  grant_self,      1'b0);
         check($sformatf("alt%0d_idle_enemy", k), grant_enemy,     1'b0);
         check($sformatf("alt%0d_idle_busy", k),  busy,            1'b0);
      end

      // 4: enemy strobes and done ignored while self owns the port
      do_reset();
      req_self  = 1'b1;
      req_enemy = 1'b1;
      tick();
      check("t4_grant_self", grant_self, 1'b1);
      plot_enemy = 1'b1;
      #1;
      check("t4_plot_enemy_only", plot, 1'b0);
      plot_self = 1'b1;
      #1;
      check("t4_plot_self", plot, 1'b1);
      plot_self = 1'b0;
      #1;
      check("t4_plot_self_low", plot, 1'b0);
      done_enemy = 1'b1;
      tick();
      done_enemy = 1'b0;
      check("t4_held_self",  grant_self,  1'b1);
      check("t4_no_enemy",   grant_enemy, 1'b0);
      req_self = 1'b0;
      tick();
      check("t4_req_drop_held", grant_self, 1'b1);
      done_self = 1'b1;
      tick();
      done_self = 1'b0;
      plot_self = 1'b1;
      #1;
      check("t4_plot_no_grant", plot, 1'b0);
      plot_self  = 1'b0;
      plot_enemy = 1'b0;

      // 5: async reset during an enemy grant
      tick();
      tick();
      check("t5_grant_enemy", grant_enemy,     1'b1);
      check("t5_select",      datapath_select, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      check("t5_rst_grant_enemy", grant_enemy,     1'b0);
      check("t5_rst_grant_self",  grant_self,      1'b0);
      check("t5_rst_busy",        busy,            1'b0);
      check("t5_rst_select",      datapath_select, 1'b0);
      req_enemy = 1'b0;
      tick();
      resetn = 1'b1;

`ifdef DRAW_ARB_WATCHDOG_EN
      // 6: watchdog forces release after 8 granted cycles
      do_reset();
      req_self = 1'b1;
      tick();
      check("t6_grant", grant_self, 1'b1);
      for (int i = 1; i < 8; i++) begin
         tick();
         check($sformatf("t6_hold%0d", i),  grant_self, 1'b1);
         check($sformatf("t6_nowd%0d", i), wd_timeout, 1'b0);
      end
      tick();
      check("t6_forced_release", grant_self, 1'b0);
      check("t6_wd_pulse",       wd_timeout, 1'b1);
      check("t6_busy_gap",       busy,       1'b1);
      tick();
      check("t6_wd_pulse_end", wd_timeout, 1'b0);
      tick();
      check("t6_regrant", grant_self, 1'b1);
      for (int i = 1; i < 8; i++) tick();
      done_self = 1'b1;
      tick();
      done_self = 1'b0;
      req_self  = 1'b0;
      check("t6_done_at_expiry_release", grant_self, 1'b0);
      check("t6_done_at_expiry_no_wd",   wd_timeout, 1'b0);
`else
      // 6: without the watchdog a grant is held indefinitely
      do_reset();
      req_self = 1'b1;
      tick();
      check("t6_grant", grant_self, 1'b1);
      for (int i = 1; i <= 12; i++) begin
         tick();
         check($sformatf("t6_hold%0d", i),  grant_self, 1'b1);
         check($sformatf("t6_nowd%0d", i), wd_timeout, 1'b0);
      end
      done_self = 1'b1;
      tick();
      done_self = 1'b0;
      req_self  = 1'b0;
      check("t6_release", grant_self, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
